knob_param_scheduler: RTL and testbench



---
 rtl/knob_param_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_knob_param_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/knob_param_scheduler.sv
// Rotary-encoder parameter editor for four 12-bit channels. A quadrature decoder
//   turns each encoder detent into one increment or decrement of the selected
//   channel, clamped to that channel's [low, high] window. A debounced button
//   cycles the selected channel. Every value change is queued as a pending bit
//   and sent downstream as (idx, data) over a valid/ready handshake.
//
// Ports
//   qzt_clk    in   single clock, rising edge
//   reset      in   synchronous active-high reset
//   rotA/rotB  in   raw encoder phases (asynchronous)
//   btnSel     in   raw channel-select button, active high (asynchronous)
//   initBus    in   4x12 reset values   (channel n = bits [12n+11:12n])
//   incBus     in   4x12 step sizes
//   lowBus     in   4x12 lower limits
//   highBus    in   4x12 upper limits
//   outBus     out  4x12 current values
//   sel        out  channel currently adjusted by the encoder
//   upd_valid  out  update request valid
//   upd_idx    out  channel of the update request
//   upd_data   out  value of the update request
//   upd_ready  in   downstream accepts the request
module knob_param_scheduler #(
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic        qzt_clk,
    input  logic        reset,
    input  logic        rotA,
    input  logic        rotB,
    input  logic        btnSel,
    input  logic [47:0] initBus,
    input  logic [47:0] incBus,
    input  logic [47:0] lowBus,
    input  logic [47:0] highBus,
    output logic [47:0] outBus,
    output logic [1:0]  sel,
    output logic        upd_valid,
    output logic [1:0]  upd_idx,
    output logic [11:0] upd_data,
    input  logic        upd_ready
);

    localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CntW-1:0] DebMax = CntW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCw, StCcw, StLock} dec_state_e;

    // Bit order {A, B, button} in both synchronizer stages.
    logic [2:0]        sync1_q, sync2_q;
    dec_state_e        dec_q, dec_d;
    logic [3:0][11:0]  value_q, value_d;
    logic [1:0]        sel_q, sel_d;
    logic              deb_q, deb_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [3:0]        pending_q, pending_d;
    logic              valid_q, valid_d;
    logic [1:0]        idx_q, idx_d;
    logic [11:0]       data_q, data_d;

    logic [3:0][11:0]  inc_a, low_a, high_a;
    logic [1:0]        ab_s;
    logic              btn_s;
    logic              step_inc, step_dec;
    logic [11:0]       cur, inc, lo, hi, inc_val, dec_val, new_val;
    logic [12:0]       sum, lo_plus_inc;
    logic [3:0]        pend_set, pend_clr;
    logic [1:0]        low_idx;

    assign inc_a  = incBus;
    assign low_a  = lowBus;
    assign high_a = highBus;
    assign ab_s   = sync2_q[2:1];
    assign btn_s  = sync2_q[0];

    // Quadrature decoder: one step per detent, LOCK waits for the 00 rest state.
    always_comb begin
        dec_d    = dec_q;
        step_inc = 1'b0;
        step_dec = 1'b0;
        if (ab_s == 2'b00) begin
            dec_d = StIdle;
        end else begin
            unique case (dec_q)
                StIdle: begin
                    if (ab_s == 2'b01) dec_d = StCw;
                    else if (ab_s == 2'b10) dec_d = StCcw;
                end
                StCw: begin
                    if (ab_s == 2'b11) begin
                        step_inc = 1'b1;
                        dec_d    = StLock;
                    end
                end
                StCcw: begin
                    if (ab_s == 2'b11) begin
                        step_dec = 1'b1;
                        dec_d    = StLock;
                    end
                end
                StLock: ;
                default: dec_d = StIdle;
            endcase
        end
    end

    // Clamped step on the currently selected channel (13-bit to catch overflow).
    always_comb begin
        cur         = value_q[sel_q];
        inc         = inc_a[sel_q];
        lo          = low_a[sel_q];
        hi          = high_a[sel_q];
        sum         = {1'b0, cur} + {1'b0, inc};
        lo_plus_inc = {1'b0, lo} + {1'b0, inc};
        inc_val     = (sum > {1'b0, hi}) ? hi : sum[11:0];
        dec_val     = ({1'b0, cur} >= lo_plus_inc) ? (cur - inc) : lo;
        new_val     = step_inc ? inc_val : (step_dec ? dec_val : cur);
        value_d        = value_q;
        value_d[sel_q] = new_val;
        pend_set       = (new_val != cur) ? (4'b0001 << sel_q) : 4'b0000;
    end

    // Button debounce; a debounced rising edge advances the selection.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (btn_s == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == DebMax) begin
            deb_d = btn_s;
            cnt_d = '0;
            if (btn_s) sel_d = sel_q + 2'd1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Update scheduler: issue the lowest pending channel whenever the slot is free.
    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (pending_q[i]) low_idx = 2'(i);
        end
        valid_d  = valid_q;
        idx_d    = idx_q;
        data_d   = data_q;
        pend_clr = 4'b0000;
        if (!valid_q || upd_ready) begin
            if (|pending_q) begin
                valid_d  = 1'b1;
                idx_d    = low_idx;
                data_d   = value_q[low_idx];
                pend_clr = 4'b0001 << low_idx;
            end else begin
                valid_d = 1'b0;
            end
        end
        // Set after clear so a same-edge change to the issued channel is reissued.
        pending_d = (pending_q & ~pend_clr) | pend_set;
    end

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            dec_q     <= StIdle;
            value_q   <= initBus;
            sel_q     <= 2'd0;
            deb_q     <= 1'b0;
            cnt_q     <= '0;
            pending_q <= 4'b1111;
            valid_q   <= 1'b0;
            idx_q     <= 2'd0;
            data_q    <= 12'd0;
        end else begin
            sync1_q   <= {rotA, rotB, btnSel};
            sync2_q   <= sync1_q;
            dec_q     <= dec_d;
            value_q   <= value_d;
            sel_q     <= sel_d;
            deb_q     <= deb_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
        end
    end

    assign outBus    = value_q;
    assign sel       = sel_q;
    assign upd_valid = valid_q;
    assign upd_idx   = idx_q;
    assign upd_data  = data_q;

endmodule

// File: tb/tb_knob_param_scheduler.sv
module tb_knob_param_scheduler;

    localparam int unsigned DEB = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rotA = 1'b0, rotB = 1'b0, btnSel = 1'b0;
    logic [47:0] initBus, incBus, lowBus, highBus;
    logic [47:0] outBus;
    logic [1:0]  sel;
    logic        upd_valid;
    logic [1:0]  upd_idx;
    logic [11:0] upd_data;
    logic        upd_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    logic [1:0]  xfer_idx[$];
    logic [11:0] xfer_data[$];

    knob_param_scheduler #(.DEB_CYCLES(DEB)) dut (
        .qzt_clk   (clk),
        .reset     (reset),
        .rotA      (rotA),
        .rotB      (rotB),
        .btnSel    (btnSel),
        .initBus   (initBus),
        .incBus    (incBus),
        .lowBus    (lowBus),
        .highBus   (highBus),
        .outBus    (outBus),
        .sel       (sel),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_data  (upd_data),
        .upd_ready (upd_ready)
    );

    always #5 clk = ~clk;

    // Log completed transfers using pre-edge values.
    always @(posedge clk) begin
        if (!reset && upd_valid && upd_ready) begin
            xfer_idx.push_back(upd_idx);
            xfer_data.push_back(upd_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        xfer_idx.delete();
        xfer_data.delete();
    endtask

    // One detent: 01 (CW) or 10 (CCW), then 11, then rest at 00.
    task automatic detent(input bit cw);
        rotA = ~cw; rotB = cw;
        tick(3);
        rotA = 1'b1; rotB = 1'b1;
        tick(3);
        rotA = 1'b0; rotB = 1'b0;
        tick(3);
    endtask

    task automatic press();
        btnSel = 1'b1;
        tick(DEB + 4);
        btnSel = 1'b0;
        tick(DEB + 4);
    endtask

    // Expects reset just released with upd_ready=1: channels 0..3 issued back to back.
    task automatic check_reissue(input string tag);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk({tag, "_valid"}, 48'(upd_valid), 48'd1);
            chk({tag, "_idx"}, 48'(upd_idx), 48'(i));
            chk({tag, "_data"}, 48'(upd_data), 48'(initBus[12*i +: 12]));
        end
        tick(1);
        chk({tag, "_drop"}, 48'(upd_valid), 48'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        clear_log();
    endtask

    initial begin
        initBus = {12'h300, 12'h200, 12'h100, 12'h800};
        incBus  = {12'h001, 12'h001, 12'h020, 12'h010};
        lowBus  = {4{12'h010}};
        highBus = {4{12'hFFF}};

        // Reset state and initial issue of all four channels.
        tick(3);
        chk("rst_valid", 48'(upd_valid), 48'd0);
        chk("rst_idx", 48'(upd_idx), 48'd0);
        chk("rst_data", 48'(upd_data), 48'd0);
        chk("rst_sel", 48'(sel), 48'd0);
        chk("rst_out", outBus, initBus);
        reset = 1'b0;
        check_reissue("init");
        clear_log();

        // CW detent on ch0 with exact latency: value moves two edges after 11 sampled.
        rotA = 1'b0; rotB = 1'b1;
        tick(3);
        rotA = 1'b1; rotB = 1'b1;
        tick(1);
        chk("lat_k", 48'(outBus[11:0]), 48'h800);
        tick(1);
        chk("lat_k1", 48'(outBus[11:0]), 48'h800);
        tick(1);
        chk("lat_k2", 48'(outBus[11:0]), 48'h810);
        chk("lat_k2_nv", 48'(upd_valid), 48'd0);
        tick(1);
        chk("upd_valid", 48'(upd_valid), 48'd1);
        chk("upd_idx", 48'(upd_idx), 48'd0);
        chk("upd_data", 48'(upd_data), 48'h810);
        tick(1);
        chk("upd_drop", 48'(upd_valid), 48'd0);
        rotA = 1'b0; rotB = 1'b0;
        tick(3);
        chk("one_upd", 48'(xfer_idx.size()), 48'd1);

        // Clamp at upper limit; second detent changes nothing and sends nothing.
        initBus[11:0] = 12'hFF8;
        do_reset();
        detent(1'b1);
        chk("clamp_val", 48'(outBus[11:0]), 48'hFFF);
        chk("clamp_n", 48'(xfer_idx.size()), 48'd1);
        if (xfer_data.size() == 1) chk("clamp_data", 48'(xfer_data[0]), 48'hFFF);
        clear_log();
        detent(1'b1);
        chk("sat_val", 48'(outBus[11:0]), 48'hFFF);
        chk("sat_n", 48'(xfer_idx.size()), 48'd0);
        chk("sat_valid", 48'(upd_valid), 48'd0);

        // Back-pressure: held request, selection change, second channel queued.
        initBus[11:0] = 12'h800;
        do_reset();
        upd_ready = 1'b0;
        detent(1'b1);
        chk("bp_valid", 48'(upd_valid), 48'd1);
        chk("bp_idx", 48'(upd_idx), 48'd0);
        chk("bp_data", 48'(upd_data), 48'h810);
        press();
        chk("bp_sel", 48'(sel), 48'd1);
        detent(1'b0);
        chk("bp_ch1", 48'(outBus[23:12]), 48'h0E0);
        chk("bp_hold_idx", 48'(upd_idx), 48'd0);
        chk("bp_hold_data", 48'(upd_data), 48'h810);
        chk("bp_hold_valid", 48'(upd_valid), 48'd1);
        upd_ready = 1'b1;
        tick(1);
        chk("bp_nxt_idx", 48'(upd_idx), 48'd1);
        chk("bp_nxt_data", 48'(upd_data), 48'h0E0);
        tick(1);
        chk("bp_drop", 48'(upd_valid), 48'd0);
        chk("bp_n", 48'(xfer_idx.size()), 48'd2);
        if (xfer_idx.size() == 2) begin
            chk("bp_x0", {34'd0, xfer_idx[0], xfer_data[0]}, {34'd0, 2'd0, 12'h810});
            chk("bp_x1", {34'd0, xfer_idx[1], xfer_data[1]}, {34'd0, 2'd1, 12'h0E0});
        end

        // Reset in CW state between 01 and 11: no step, full reissue.
        do_reset();
        detent(1'b1);
        chk("mid_pre", 48'(outBus[11:0]), 48'h810);
        rotA = 1'b0; rotB = 1'b1;
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        rotA = 1'b1; rotB = 1'b1;
        check_reissue("mid");
        tick(3);
        chk("mid_out", outBus, initBus);
        rotA = 1'b0; rotB = 1'b0;
        tick(3);

        // Debounce: short pulse ignored, full presses step sel 1,2,3,0.
        do_reset();
        btnSel = 1'b1;
        tick(DEB - 2);
        btnSel = 1'b0;
        tick(DEB + 4);
        chk("short_press", 48'(sel), 48'd0);
        press();
        chk("press1", 48'(sel), 48'd1);
        press();
        chk("press2", 48'(sel), 48'd2);
        press();
        chk("press3", 48'(sel), 48'd3);
        press();
        chk("press4", 48'(sel), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
